// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter for the game score.
// Watches the binary score, runs an iterative double-dabble conversion whenever
// it changes, and presents a stable BCD word plus a leading-zero blank mask to
// the 7-segment driver.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for bin_in to differ from the last converted value
// SHIFT  | one add-3/shift-left step per clock, BIN_W steps in total
// DONE   | publish result, remember converted value, pulse valid
module score_bcd_converter #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  valid,
  output logic                  busy,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  function automatic longint unsigned f_pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest value representable in DIGITS decimal digits.
  localparam longint unsigned MAX_VAL = f_pow10(DIGITS) - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start;

  logic [SH_W-1:0]    r_shreg;
  logic [SH_W-1:0]    w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_cap_bin;
  logic [BIN_W-1:0]   r_last_bin;

  logic [BCD_W-1:0]   w_bcd_res;
  logic [DIGITS-1:0]  w_lz;
  logic               w_ovf;

  logic [BCD_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_lz;
  logic               r_ovf;
  logic               r_valid;

  // Compare against the last *converted* value so a change made while busy
  // is picked up on the first IDLE edge afterwards.
  assign w_start = (r_state == S_IDLE) && (bin_in != r_last_bin);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-nibble add-3 on the BCD field; nibbles never carry into each other.
  always_comb begin
    w_adj = r_shreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shreg[BIN_W+4*d +: 4] >= 4'd5)
        w_adj[BIN_W+4*d +: 4] = r_shreg[BIN_W+4*d +: 4] + 4'd3;
    end
  end

  assign w_bcd_res = r_shreg[SH_W-1 -: BCD_W];
  assign w_ovf     = 64'(r_cap_bin) > MAX_VAL;

  // Leading-zero mask: digit i blanks when it and everything above it are zero;
  // digit 0 is never blanked so a zero score still shows one '0'.
  always_comb begin : lz_calc
    logic v_zero_above;
    w_lz         = '0;
    v_zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      v_zero_above = v_zero_above && (w_bcd_res[4*d +: 4] == 4'd0);
      w_lz[d]      = v_zero_above;
    end
  end

  // Datapath: load, iterate, then publish the result in one atomic update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_cap_bin  <= '0;
      r_last_bin <= '0;
      r_bcd      <= '0;
      r_lz       <= {{(DIGITS-1){1'b1}}, 1'b0};
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg   <= {{BCD_W{1'b0}}, bin_in};
            r_cap_bin <= bin_in;
            r_cnt     <= '0;
          end
        end
        S_SHIFT: begin
          r_shreg <= w_adj << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          if (w_ovf) begin
            r_bcd <= {DIGITS{4'h9}};
            r_lz  <= '0;
          end else begin
            r_bcd <= w_bcd_res;
            r_lz  <= w_lz;
          end
          r_ovf      <= w_ovf;
          r_last_bin <= r_cap_bin;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd_out = r_bcd;
  assign lz_mask = r_lz;
  assign ovf     = r_ovf;
  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: default 11-bit/4-digit instance plus
// a 14-bit instance that can overflow four digits.
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] bin_a;
  logic [15:0] bcd_a;
  logic [3:0]  lz_a;
  logic        valid_a, busy_a, ovf_a;
  logic [13:0] bin_b;
  logic [15:0] bcd_b;
  logic [3:0]  lz_b;
  logic        valid_b, busy_b, ovf_b;

  int checks   = 0;
  int failures = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;
  int n, nb, v0;

  always #5 clk = ~clk;

  score_bcd_converter #(.BIN_W(11), .DIGITS(4)) dut_a (
    .clk(clk), .rst(rst), .bin_in(bin_a), .bcd_out(bcd_a), .lz_mask(lz_a),
    .valid(valid_a), .busy(busy_a), .ovf(ovf_a)
  );

  score_bcd_converter #(.BIN_W(14), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .bin_in(bin_b), .bcd_out(bcd_b), .lz_mask(lz_b),
    .valid(valid_b), .busy(busy_b), .ovf(ovf_b)
  );

  // Count valid pulses away from the active edge.
  always @(negedge clk) begin
    if (valid_a === 1'b1) vcnt_a++;
    if (valid_b === 1'b1) vcnt_b++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until valid is seen (bounded); n = edges taken, nb = busy cycles before valid.
  task automatic wait_valid(input bit sel, output int cnt, output int bcnt);
    cnt  = 0;
    bcnt = 0;
    while (cnt < 60) begin
      tick();
      cnt++;
      if ((sel ? valid_b : valid_a) === 1'b1) break;
      if ((sel ? busy_b : busy_a) === 1'b1) bcnt++;
    end
  endtask

  initial begin
    rst   = 1'b0;
    bin_a = '0;
    bin_b = '0;
    repeat (3) tick();
    chk("rst_bcd",   64'(bcd_a),   64'h0000);
    chk("rst_lz",    64'(lz_a),    64'b1110);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_ovf",   64'(ovf_a),   64'd0);

    // 1: zero input after reset never triggers a conversion
    rst = 1'b1;
    repeat (20) tick();
    chk("idle0_vcnt", 64'(vcnt_a), 64'd0);
    chk("idle0_busy", 64'(busy_a), 64'd0);
    chk("idle0_bcd",  64'(bcd_a),  64'h0000);
    chk("idle0_lz",   64'(lz_a),   64'b1110);

    // 2: 1234, latency and busy length
    bin_a = 11'd1234;
    wait_valid(1'b0, n, nb);
    chk("t2_lat",  64'(n),     64'd13);
    chk("t2_busy", 64'(nb),    64'd12);
    chk("t2_bcd",  64'(bcd_a), 64'h1234);
    chk("t2_lz",   64'(lz_a),  64'b0000);
    chk("t2_ovf",  64'(ovf_a), 64'd0);
    tick();
    chk("t2_vpulse", 64'(valid_a), 64'd0);
    chk("t2_idle",   64'(busy_a),  64'd0);

    // 3: max value, then small value with blanking
    bin_a = 11'd2047;
    wait_valid(1'b0, n, nb);
    chk("t3_bcd_max", 64'(bcd_a), 64'h2047);
    chk("t3_lz_max",  64'(lz_a),  64'b0000);
    bin_a = 11'd7;
    wait_valid(1'b0, n, nb);
    chk("t3_bcd_7", 64'(bcd_a), 64'h0007);
    chk("t3_lz_7",  64'(lz_a),  64'b1110);
    tick();

    // 4: change during conversion -> back-to-back conversions
    v0    = vcnt_a;
    bin_a = 11'd5;
    tick();
    tick();
    tick();
    bin_a = 11'd9;
    wait_valid(1'b0, n, nb);
    chk("t4_lat1", 64'(n),     64'd10);
    chk("t4_bcd1", 64'(bcd_a), 64'h0005);
    tick();
    chk("t4_restart", 64'(busy_a), 64'd1);
    chk("t4_hold",    64'(bcd_a),  64'h0005);
    wait_valid(1'b0, n, nb);
    chk("t4_lat2", 64'(n),     64'd12);
    chk("t4_bcd2", 64'(bcd_a), 64'h0009);
    chk("t4_lz2",  64'(lz_a),  64'b1110);
    repeat (5) tick();
    chk("t4_npulse", 64'(vcnt_a - v0), 64'd2);

    // 5: reset mid-conversion aborts, then value re-converts
    bin_a = 11'd999;
    tick();
    repeat (6) tick();
    chk("t5_busy", 64'(busy_a), 64'd1);
    v0  = vcnt_a;
    rst = 1'b0;
    #1;
    chk("t5_rst_bcd",   64'(bcd_a),   64'h0000);
    chk("t5_rst_lz",    64'(lz_a),    64'b1110);
    chk("t5_rst_busy",  64'(busy_a),  64'd0);
    chk("t5_rst_valid", 64'(valid_a), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    chk("t5_nopulse", 64'(vcnt_a - v0), 64'd0);
    wait_valid(1'b0, n, nb);
    chk("t5_lat", 64'(n),     64'd13);
    chk("t5_bcd", 64'(bcd_a), 64'h0999);
    chk("t5_lz",  64'(lz_a),  64'b1000);

    // 6: 14-bit instance, overflow and recovery
    bin_b = 14'd12000;
    wait_valid(1'b1, n, nb);
    chk("t6_lat",     64'(n),     64'd16);
    chk("t6_ovf_bcd", 64'(bcd_b), 64'h9999);
    chk("t6_ovf",     64'(ovf_b), 64'd1);
    chk("t6_ovf_lz",  64'(lz_b),  64'b0000);
    bin_b = 14'd42;
    wait_valid(1'b1, n, nb);
    chk("t6_bcd42", 64'(bcd_b), 64'h0042);
    chk("t6_ovf42", 64'(ovf_b), 64'd0);
    chk("t6_lz42",  64'(lz_b),  64'b1100);
    bin_b = 14'd9999;
    wait_valid(1'b1, n, nb);
    chk("t6_bcd9999", 64'(bcd_b), 64'h9999);
    chk("t6_ovf9999", 64'(ovf_b), 64'd0);
    bin_b = 14'd10000;
    wait_valid(1'b1, n, nb);
    chk("t6_ovf10000", 64'(ovf_b), 64'd1);
    chk("t6_lz10000",  64'(lz_b),  64'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
